// File: rtl/status_flag_unit.sv
// NZCV flag producer: computes condition flags from ALU results, with a small
// save/restore stack for exception entry/return and a direct write path.
module status_flag_unit #(
    parameter int WIDTH       = 32,
    parameter int STACK_DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [2:0]                   flag_op,
    input  logic [WIDTH-1:0]             alu_operand_a,
    input  logic [WIDTH-1:0]             alu_operand_b,
    input  logic [WIDTH-1:0]             alu_result,
    input  logic                         alu_carry_out,
    input  logic                         shifter_carry,
    input  logic [3:0]                   flag_wdata,
    input  logic                         clear_error,
    output logic                         negative_flag,
    output logic                         zero_flag,
    output logic                         carry_flag,
    output logic                         overflow_flag,
    output logic [$clog2(STACK_DEPTH):0] stack_count,
    output logic                         stack_overflow,
    output logic                         stack_underflow
);

    localparam int AW = $clog2(STACK_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        OP_HOLD  = 3'd0,
        OP_ADD   = 3'd1,
        OP_SUB   = 3'd2,
        OP_LOGIC = 3'd3,
        OP_SHIFT = 3'd4,
        OP_WRITE = 3'd5,
        OP_PUSH  = 3'd6,
        OP_POP   = 3'd7
    } op_e;

    op_e op;

    logic [3:0]    nzcv_q, nzcv_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [3:0]    stack_q [STACK_DEPTH];

    logic          push_we;
    logic          ovf_set, unf_set;
    logic [AW-1:0] push_idx, pop_idx;
    logic          full, empty;
    logic          a_s, b_s, res_n, res_z;
    logic          add_v, sub_v;
    logic          unused_operand_bits;

    assign op = op_e'(flag_op);

    assign a_s   = alu_operand_a[WIDTH-1];
    assign b_s   = alu_operand_b[WIDTH-1];
    assign res_n = alu_result[WIDTH-1];
    assign res_z = (alu_result == '0);

    // Signed overflow from sign bits only; b is the un-inverted operand.
    assign add_v = (a_s == b_s) & (res_n != a_s);
    assign sub_v = (a_s != b_s) & (res_n != a_s);

    assign unused_operand_bits = ^{alu_operand_a[WIDTH-2:0],
                                   alu_operand_b[WIDTH-2:0]};

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign push_idx = count_q[AW-1:0];
    assign pop_idx  = AW'(count_q - CW'(1));

    always_comb begin
        nzcv_d  = nzcv_q;
        count_d = count_q;
        push_we = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (op)
            OP_HOLD: begin
            end
            OP_ADD: begin
                nzcv_d = {res_n, res_z, alu_carry_out, add_v};
            end
            OP_SUB: begin
                nzcv_d = {res_n, res_z, alu_carry_out, sub_v};
            end
            OP_LOGIC: begin
                nzcv_d[3:2] = {res_n, res_z};
            end
            OP_SHIFT: begin
                nzcv_d[3:1] = {res_n, res_z, shifter_carry};
            end
            OP_WRITE: begin
                nzcv_d = flag_wdata;
            end
            OP_PUSH: begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    push_we = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            OP_POP: begin
                if (empty) begin
                    unf_set = 1'b1;
                end else begin
                    nzcv_d  = stack_q[pop_idx];
                    count_d = count_q - CW'(1);
                end
            end
        endcase
        // A new error event in the same cycle as a clear leaves the bit set.
        ovf_d = (ovf_q & ~clear_error) | ovf_set;
        unf_d = (unf_q & ~clear_error) | unf_set;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            nzcv_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            nzcv_q  <= nzcv_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_we && !reset) begin
            stack_q[push_idx] <= nzcv_q;
        end
    end

    assign negative_flag   = nzcv_q[3];
    assign zero_flag       = nzcv_q[2];
    assign carry_flag      = nzcv_q[1];
    assign overflow_flag   = nzcv_q[0];
    assign stack_count     = count_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Self-checking bench for status_flag_unit: directed vector table, stack
// corner sequences, and randomized ops against a queue-based reference model.
module tb_status_flag_unit;

    localparam int W  = 32;
    localparam int SD = 4;

    localparam logic [2:0] HOLD  = 3'd0;
    localparam logic [2:0] ADD   = 3'd1;
    localparam logic [2:0] SUB   = 3'd2;
    localparam logic [2:0] LOGIC = 3'd3;
    localparam logic [2:0] SHIFT = 3'd4;
    localparam logic [2:0] WRITE = 3'd5;
    localparam logic [2:0] PUSH  = 3'd6;
    localparam logic [2:0] POP   = 3'd7;

    logic         clock;
    logic         reset;
    logic [2:0]   flag_op;
    logic [W-1:0] alu_operand_a;
    logic [W-1:0] alu_operand_b;
    logic [W-1:0] alu_result;
    logic         alu_carry_out;
    logic         shifter_carry;
    logic [3:0]   flag_wdata;
    logic         clear_error;
    logic         negative_flag;
    logic         zero_flag;
    logic         carry_flag;
    logic         overflow_flag;
    logic [2:0]   stack_count;
    logic         stack_overflow;
    logic         stack_underflow;

    int checks = 0;
    int errors = 0;

    status_flag_unit #(.WIDTH(W), .STACK_DEPTH(SD)) dut (
        .clock          (clock),
        .reset          (reset),
        .flag_op        (flag_op),
        .alu_operand_a  (alu_operand_a),
        .alu_operand_b  (alu_operand_b),
        .alu_result     (alu_result),
        .alu_carry_out  (alu_carry_out),
        .shifter_carry  (shifter_carry),
        .flag_wdata     (flag_wdata),
        .clear_error    (clear_error),
        .negative_flag  (negative_flag),
        .zero_flag      (zero_flag),
        .carry_flag     (carry_flag),
        .overflow_flag  (overflow_flag),
        .stack_count    (stack_count),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic         cout;
        logic         sh;
        logic [3:0]   wd;
        logic         clr;
        logic [3:0]   en;
        int           ec;
        logic         eo;
        logic         eu;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    logic [3:0] m_nzcv;
    logic [3:0] m_stack[$];
    logic       m_ovf;
    logic       m_unf;

    function automatic vec_t mk(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                logic [W-1:0] r, logic cout, logic sh,
                                logic [3:0] wd, logic [3:0] en, int ec);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.r = r; v.cout = cout; v.sh = sh;
        v.wd = wd; v.clr = 1'b0; v.en = en; v.ec = ec; v.eo = 1'b0; v.eu = 1'b0;
        return v;
    endfunction

    task automatic drive(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b,
                         logic [W-1:0] r, logic cout, logic sh,
                         logic [3:0] wd, logic clr);
        flag_op       = op;
        alu_operand_a = a;
        alu_operand_b = b;
        alu_result    = r;
        alu_carry_out = cout;
        shifter_carry = sh;
        flag_wdata    = wd;
        clear_error   = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic op_only(logic [2:0] op, logic [3:0] wd, logic clr);
        drive(op, '0, '0, '0, 1'b0, 1'b0, wd, clr);
    endtask

    task automatic check(string name, logic [3:0] en, int ec, logic eo, logic eu);
        logic [3:0] got;
        got = {negative_flag, zero_flag, carry_flag, overflow_flag};
        checks++;
        if (got !== en || int'(stack_count) != ec ||
            stack_overflow !== eo || stack_underflow !== eu) begin
            errors++;
            $display("FAIL %s: got nzcv=%b cnt=%0d ovf=%b unf=%b, expected nzcv=%b cnt=%0d ovf=%b unf=%b",
                     name, got, stack_count, stack_overflow, stack_underflow,
                     en, ec, eo, eu);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        op_only(HOLD, 4'h0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        flag_op       = HOLD;
        alu_operand_a = '0;
        alu_operand_b = '0;
        alu_result    = '0;
        alu_carry_out = 1'b0;
        shifter_carry = 1'b0;
        flag_wdata    = '0;
        clear_error   = 1'b0;

        // Stateful directed table, applied in order from reset
        vecs.push_back(mk(ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 0, 4'b1001, 0));
        vecs.push_back(mk(SUB, 32'h5, 32'h5, 32'h0, 1, 0, 0, 4'b0110, 0));
        vecs.push_back(mk(LOGIC, 0, 0, 32'hF0000000, 0, 0, 0, 4'b1010, 0));
        vecs.push_back(mk(WRITE, 0, 0, 0, 0, 0, 4'b1111, 4'b1111, 0));
        vecs.push_back(mk(PUSH, 0, 0, 0, 0, 0, 0, 4'b1111, 1));
        vecs.push_back(mk(WRITE, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1));
        vecs.push_back(mk(POP, 0, 0, 0, 0, 0, 0, 4'b1111, 0));
        vecs.push_back(mk(SHIFT, 0, 0, 32'h0, 0, 1, 0, 4'b0111, 0));
        vecs.push_back(mk(HOLD, 32'h80000000, 32'h1, 32'h0, 0, 0, 4'b1010, 4'b0111, 0));
        vecs.push_back(mk(SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 0, 0, 0, 4'b1000, 0));
        vecs.push_back(mk(SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1, 0, 0, 4'b0011, 0));
        vecs.push_back(mk(ADD, 32'h80000000, 32'h80000000, 32'h0, 1, 0, 0, 4'b0111, 0));

        @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_state", 4'b0000, 0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r,
                  vecs[i].cout, vecs[i].sh, vecs[i].wd, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].en, vecs[i].ec,
                  vecs[i].eo, vecs[i].eu);
        end

        // Fill the stack, then overflow on the fifth push
        do_reset();
        for (int i = 0; i < SD; i++) begin
            op_only(WRITE, 4'(1 << i), 1'b0);
            op_only(PUSH, 4'h0, 1'b0);
            check($sformatf("fill_push%0d", i), 4'(1 << i), i + 1, 1'b0, 1'b0);
        end
        op_only(PUSH, 4'h0, 1'b0);
        check("push_full", 4'b1000, 4, 1'b1, 1'b0);
        for (int i = SD - 1; i >= 0; i--) begin
            op_only(POP, 4'h0, 1'b0);
            check($sformatf("lifo_pop%0d", i), 4'(1 << i), i, 1'b1, 1'b0);
        end

        // Underflow, clear, and clear colliding with a new underflow
        op_only(POP, 4'h0, 1'b0);
        check("pop_empty", 4'b0001, 0, 1'b1, 1'b1);
        op_only(HOLD, 4'h0, 1'b1);
        check("clear_err", 4'b0001, 0, 1'b0, 1'b0);
        op_only(POP, 4'h0, 1'b1);
        check("clear_vs_set", 4'b0001, 0, 1'b0, 1'b1);

        // Reset between PUSH and POP empties the stack
        do_reset();
        op_only(WRITE, 4'b0101, 1'b0);
        op_only(PUSH, 4'h0, 1'b0);
        op_only(PUSH, 4'h0, 1'b0);
        check("two_push", 4'b0101, 2, 1'b0, 1'b0);
        reset = 1'b1;
        op_only(POP, 4'h0, 1'b0);
        reset = 1'b0;
        check("reset_mid", 4'b0000, 0, 1'b0, 1'b0);
        op_only(POP, 4'h0, 1'b0);
        check("pop_after_reset", 4'b0000, 0, 1'b0, 1'b1);

        // Randomized ops against the reference model
        do_reset();
        m_nzcv = 4'b0000;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        for (int n = 0; n < 600; n++) begin
            logic [2:0]   op;
            logic [W-1:0] a, b, r;
            logic [W:0]   wide;
            logic         cout, sh, clr, ev_o, ev_u;
            logic [3:0]   wd;
            longint       sa, sb, s;
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            r    = $urandom;
            if ($urandom_range(0, 7) == 0) r = '0;
            cout = 1'($urandom);
            sh   = 1'($urandom);
            wd   = 4'($urandom);
            clr  = ($urandom_range(0, 7) == 0);
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            ev_o = 1'b0;
            ev_u = 1'b0;
            case (op)
                ADD: begin
                    wide = {1'b0, a} + {1'b0, b};
                    r = wide[W-1:0];
                    cout = wide[W];
                    s = sa + sb;
                    m_nzcv = {r[W-1], r == 0, cout,
                              (s > 64'sd2147483647) || (s < -64'sd2147483648)};
                end
                SUB: begin
                    r = a - b;
                    cout = (a >= b);
                    s = sa - sb;
                    m_nzcv = {r[W-1], r == 0, cout,
                              (s > 64'sd2147483647) || (s < -64'sd2147483648)};
                end
                LOGIC: m_nzcv[3:2] = {r[W-1], r == 0};
                SHIFT: m_nzcv[3:1] = {r[W-1], r == 0, sh};
                WRITE: m_nzcv = wd;
                PUSH: begin
                    if (m_stack.size() < SD) m_stack.push_back(m_nzcv);
                    else ev_o = 1'b1;
                end
                POP: begin
                    if (m_stack.size() > 0) m_nzcv = m_stack.pop_back();
                    else ev_u = 1'b1;
                end
                default: begin
                end
            endcase
            if (clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            m_ovf = m_ovf | ev_o;
            m_unf = m_unf | ev_u;
            drive(op, a, b, r, cout, sh, wd, clr);
            check($sformatf("rand%0d_op%0d", n, op), m_nzcv, m_stack.size(),
                  m_ovf, m_unf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
